i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target (slave) holding a small byte-wide register file. It is the downstream stage of the on-chip I2C master: it sits on the same open-drain SCL/SDA pair (gpio8/gpio9) and answers that master's transactions. It gives the user project a self-contained, loop-back I2C endpoint for bring-up and test. A host-side port lets local logic read and preload the registers and observe I2C writes.

## Interface
- `TARGET_ADDR`, default 7'h50: 7-bit I2C address the block responds to.
- `NREGS`, default 16: number of 8-bit registers (power of two, 2..256).
- `PTR_W`, default $clog2(NREGS): register pointer width.

Ports:
- `wb_clk_i` in, 1: the only clock; system clock, at least 8x the SCL rate.
- `wb_rst_i` in, 1: reset; synchronous, active-high.
- `scl_i` in, 1: SCL pad input (asynchronous).
- `sda_i` in, 1: SDA pad input (asynchronous).
- `sda_o` out, 1: SDA output value; constant 0 (open-drain).
- `sda_oen_o` out, 1: SDA output enable, active-high; 1 = pull SDA low.
- `hst_we` in, 1: host write strobe.
- `hst_addr` in, PTR_W: host register address, shared by reads and writes.
- `hst_wdata` in, 8: host write data.
- `hst_rdata` out, 8: registered read of reg[hst_addr], one-cycle latency.
- `wr_valid` out, 1: one-cycle pulse after each I2C data byte is written.
- `wr_addr` out, PTR_W: register index of that write.
- `wr_data` out, 8: byte value of that write.
- `busy` out, 1: high from START until STOP, or until reset.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer, then an edge-detect flop. Rise and fall events use the synchronized values.
- START is an SDA fall while SCL is high. STOP is an SDA rise while SCL is high. Both are recognised in every state.
- START in any state, including a repeated START, goes to ADDR with the bit counter cleared.
- STOP in any state goes to IDLE, releases SDA and clears `busy`.
- FSM states:
  - IDLE: waiting for START.
  - ADDR: shift 8 bits MSB-first on SCL rise.
    - Address match: go to ACK_ADDR.
    - Mismatch: go to IGNORE, which waits for START or STOP and never drives SDA.
  - ACK_ADDR: drive ACK.
    - R/W=0: go to PTR.
    - R/W=1: load the shift register from reg[ptr], then go to RDATA.
  - PTR: receive 8 bits, ACK, then set ptr to the low PTR_W bits.
  - WDATA: receive 8 bits, ACK. Then write reg[ptr], pulse `wr_valid` and increment ptr.
  - RDATA: shift out 8 bits MSB-first.
  - RACK: release SDA and sample the master's bit on SCL rise.
    - ACK (0): increment ptr, reload, return to RDATA.
    - NACK (1): go to IGNORE.
- Pointer arithmetic is modulo NREGS: pointer NREGS-1 wraps to 0.
- The pointer persists across transactions. This allows a write-pointer / repeated-START / read sequence.
- Simultaneous I2C write and `hst_we` to the same register: the I2C write wins. A host write to a different register completes normally.
- Unused address bits: none beyond PTR_W. High bits of the pointer byte are dropped.

## Timing
- Reset values:
  - `sda_oen_o`=0, `sda_o`=0, `busy`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `hst_rdata`=0.
  - ptr=0, all registers 0, FSM in IDLE.
- Reset mid-transaction releases SDA on the next edge and ignores all bus activity until the next START.
- SDA changes only one clock after a detected SCL fall, which gives hold time.
- ACK assertion:
  - Asserted after the SCL fall that ends bit 8.
  - Released after the following SCL fall.
- Read data: bit 7 is driven after the SCL fall following the address ACK. Each next bit follows the next SCL fall.
- Input-to-event latency is 3 clocks: 2 sync + 1 edge detect.
- Register update and `wr_valid` occur in the same clock, 1 clock after the SCL rise that samples data bit 0.

## Structure
- Package `i2c_target_pkg` holds:
  - the state enum (IDLE, ADDR, ACK_ADDR, PTR, WDATA, RDATA, RACK, IGNORE);
  - the ACK and NACK constants.
- Sub-module `i2c_bus_sync` holds the synchronizers and edge/START/STOP detection. It outputs `scl_rise`, `scl_fall`, `start`, `stop` and `sda_s`.
- The register file is inferred flops in the top module.

## Test plan
- Write: START, 0xA0, 0x03, 0x5A, STOP
  - Three ACKs; reg[3]=0x5A.
  - Exactly one `wr_valid` pulse, with `wr_addr`=3.
- Combined read: START, 0xA0, 0x03, repeated START, 0xA1, read 2 bytes, master ACK then NACK, STOP
  - Reads 0x5A, then reg[4].
  - Block releases SDA after the NACK.
- Wrong address: START, 0xA2, …, STOP
  - `sda_oen_o` stays 0 throughout; no register changes.
- Pointer wrap: pointer 0x0F, write 0x11, 0x22
  - reg[15]=0x11, reg[0]=0x22.
- Host/I2C collision: `hst_we` to reg[5] with 0xFF in the same clock as the I2C write of 0x33 to reg[5]
  - reg[5]=0x33.
  - `hst_rdata` for address 5 shows 0x33 one cycle later.
- STOP mid-byte, then `wb_rst_i` during ACK_ADDR
  - STOP: IDLE, `busy`=0.
  - Reset: SDA released next edge, ptr=0, next valid transaction ACKed.

Source files
------------

// File: rtl/i2c_target_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_pkg
//  Description : Shared types and constants for the I2C target register block.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_target_pkg;

   // Protocol state of the I2C target
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ACK_ADDR = 3'd2,
      PTR      = 3'd3,
      WDATA    = 3'd4,
      RDATA    = 3'd5,
      RACK     = 3'd6,
      IGNORE   = 3'd7
   } state_e;

   // SDA level of an acknowledge / not-acknowledge bit
   localparam logic c_ACK  = 1'b0;
   localparam logic c_NACK = 1'b1;

endpackage : i2c_target_pkg
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_sync
//  Description : Synchronises the SCL/SDA pads into the system clock domain
//                and derives SCL edges plus START/STOP conditions.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic sda_s_o
);

   logic scl_meta_q, scl_sync_q, scl_prev_q;
   logic sda_meta_q, sda_sync_q, sda_prev_q;

   // Two-flop synchronisers followed by one history flop; reset to idle-bus high
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_meta_q <= scl_i;
         scl_sync_q <= scl_meta_q;
         scl_prev_q <= scl_sync_q;
         sda_meta_q <= sda_i;
         sda_sync_q <= sda_meta_q;
         sda_prev_q <= sda_sync_q;
      end
   end

   assign scl_rise_o = scl_sync_q & ~scl_prev_q;
   assign scl_fall_o = ~scl_sync_q & scl_prev_q;
   // SDA may only move while SCL is high for START/STOP, so require SCL stable high
   assign start_o    = sda_prev_q & ~sda_sync_q & scl_sync_q & scl_prev_q;
   assign stop_o     = ~sda_prev_q & sda_sync_q & scl_sync_q & scl_prev_q;
   assign sda_s_o    = sda_sync_q;

endmodule : i2c_bus_sync
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_regs
//  Description : I2C target exposing a byte-wide register file, with a local
//                host port for preload/readback and an I2C write monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_regs
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         NREGS       = 16,
   parameter int         PTR_W       = $clog2(NREGS)
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_o,
   output logic             sda_oen_o,
   input  logic             hst_we,
   input  logic [PTR_W-1:0] hst_addr,
   input  logic [7:0]       hst_wdata,
   output logic [7:0]       hst_rdata,
   output logic             wr_valid,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy
);

   logic scl_rise, scl_fall, start, stop, sda_s;

   i2c_bus_sync u_sync (
      .clk_i      (wb_clk_i),
      .rst_i      (wb_rst_i),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start),
      .stop_o     (stop),
      .sda_s_o    (sda_s)
   );

   state_e           state_q;
   logic [3:0]       bitcnt_q;   // bits handled in the current byte; 8 = byte complete
   logic [7:0]       shift_q;
   logic [PTR_W-1:0] ptr_q;
   logic             rw_q;
   logic             ack_q;      // ACK bit currently being driven
   logic             sda_oen_q;
   logic             busy_q;
   logic             wr_valid_q;
   logic [PTR_W-1:0] wr_addr_q;
   logic [7:0]       wr_data_q;
   logic [7:0]       hst_rdata_q;
   logic [7:0]       regs_q [NREGS];

   logic [7:0]       rx_byte_d;
   logic [PTR_W-1:0] ptr_inc_d;
   logic             i2c_we_d;

   assign rx_byte_d = {shift_q[6:0], sda_s};
   assign ptr_inc_d = ptr_q + 1'b1;
   assign i2c_we_d  = (state_q == WDATA) && scl_rise && (bitcnt_q == 4'd7)
                      && !start && !stop;

   // Protocol FSM: bit reception, ACK generation, read shifting and pointer
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         bitcnt_q   <= '0;
         shift_q    <= '0;
         ptr_q      <= '0;
         rw_q       <= 1'b0;
         ack_q      <= 1'b0;
         sda_oen_q  <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_valid_q <= 1'b0;
         if (start) begin
            state_q   <= ADDR;
            bitcnt_q  <= '0;
            ack_q     <= 1'b0;
            sda_oen_q <= 1'b0;
            busy_q    <= 1'b1;
         end else if (stop) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            ack_q     <= 1'b0;
            sda_oen_q <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               ADDR: begin
                  if (scl_rise) begin
                     shift_q <= rx_byte_d;
                     if (bitcnt_q == 4'd7) begin
                        bitcnt_q <= '0;
                        if (rx_byte_d[7:1] == TARGET_ADDR) begin
                           rw_q    <= rx_byte_d[0];
                           state_q <= ACK_ADDR;
                        end else begin
                           state_q <= IGNORE;
                        end
                     end else begin
                        bitcnt_q <= bitcnt_q + 4'd1;
                     end
                  end
               end
               ACK_ADDR: begin
                  if (scl_fall) begin
                     if (!ack_q) begin
                        sda_oen_q <= ~c_ACK;
                        ack_q     <= 1'b1;
                     end else begin
                        ack_q <= 1'b0;
                        if (rw_q) begin
                           // Read: bit 7 goes out on the fall that ends the ACK
                           shift_q   <= regs_q[ptr_q];
                           sda_oen_q <= ~regs_q[ptr_q][7];
                           state_q   <= RDATA;
                        end else begin
                           sda_oen_q <= 1'b0;
                           state_q   <= PTR;
                        end
                     end
                  end
               end
               PTR, WDATA: begin
                  if (scl_rise && (bitcnt_q != 4'd8)) begin
                     shift_q  <= rx_byte_d;
                     bitcnt_q <= bitcnt_q + 4'd1;
                     if (i2c_we_d) begin
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= ptr_q;
                        wr_data_q  <= rx_byte_d;
                        ptr_q      <= ptr_inc_d;
                     end
                  end
                  if (scl_fall && (bitcnt_q == 4'd8)) begin
                     if (!ack_q) begin
                        sda_oen_q <= ~c_ACK;
                        ack_q     <= 1'b1;
                     end else begin
                        sda_oen_q <= 1'b0;
                        ack_q     <= 1'b0;
                        bitcnt_q  <= '0;
                        if (state_q == PTR) begin
                           ptr_q   <= shift_q[PTR_W-1:0];
                           state_q <= WDATA;
                        end
                     end
                  end
               end
               RDATA: begin
                  if (scl_rise && (bitcnt_q != 4'd8)) begin
                     bitcnt_q <= bitcnt_q + 4'd1;
                  end
                  if (scl_fall) begin
                     if (bitcnt_q == 4'd8) begin
                        sda_oen_q <= 1'b0;
                        bitcnt_q  <= '0;
                        state_q   <= RACK;
                     end else begin
                        shift_q   <= {shift_q[6:0], 1'b0};
                        sda_oen_q <= ~shift_q[6];
                     end
                  end
               end
               RACK: begin
                  // bitcnt_q == 8 marks "master acknowledged, next byte loaded"
                  if (scl_rise && (bitcnt_q != 4'd8)) begin
                     if (sda_s == c_ACK) begin
                        ptr_q    <= ptr_inc_d;
                        shift_q  <= regs_q[ptr_inc_d];
                        bitcnt_q <= 4'd8;
                     end else begin
                        state_q <= IGNORE;
                     end
                  end else if (scl_fall && (bitcnt_q == 4'd8)) begin
                     sda_oen_q <= ~shift_q[7];
                     bitcnt_q  <= '0;
                     state_q   <= RDATA;
                  end
               end
               IDLE, IGNORE: begin
                  sda_oen_q <= 1'b0;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Register file and host readback; an I2C write beats a same-address host write
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         hst_rdata_q <= '0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         hst_rdata_q <= regs_q[hst_addr];
         for (int i = 0; i < NREGS; i++) begin
            if (i2c_we_d && (ptr_q == PTR_W'(i))) begin
               regs_q[i] <= rx_byte_d;
            end else if (hst_we && (hst_addr == PTR_W'(i))) begin
               regs_q[i] <= hst_wdata;
            end
         end
      end
   end

   assign sda_o     = 1'b0;
   assign sda_oen_o = sda_oen_q;
   assign busy      = busy_q;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign hst_rdata = hst_rdata_q;

endmodule : i2c_target_regs
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target_regs
//  Description : Self-checking bench: bit-banged I2C master, register model
//                and scoreboard queues for ACKs, read data and write events.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regs;

   localparam int Q = 10;   // quarter SCL period in system clocks

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       hst_we = 1'b0;
   logic [3:0] hst_addr = 4'd0;
   logic [7:0] hst_wdata = 8'd0;

   wire        sda_o, sda_oen_o, wr_valid, busy;
   wire [7:0]  hst_rdata, wr_data;
   wire [3:0]  wr_addr;
   wire        sda_line = sda_m & ~sda_oen_o;

   i2c_target_regs dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .scl_i     (scl_m),
      .sda_i     (sda_line),
      .sda_o     (sda_o),
      .sda_oen_o (sda_oen_o),
      .hst_we    (hst_we),
      .hst_addr  (hst_addr),
      .hst_wdata (hst_wdata),
      .hst_rdata (hst_rdata),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model and scoreboards
   typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
   logic [7:0] m_regs [16];
   logic [3:0] m_ptr = 4'd0;
   logic [7:0] exp_bus_q [$];
   wr_t        exp_wr_q [$];
   wr_t        e_wr;
   int         wr_cnt = 0;
   int         wr_extra = 0;
   int         oen_cnt = 0;

   always @(negedge clk) begin
      if (sda_oen_o) oen_cnt++;
      if (!rst && wr_valid) begin
         wr_cnt++;
         if (exp_wr_q.size() == 0) begin
            wr_extra++;
         end else begin
            e_wr = exp_wr_q.pop_front();
            chk("wr_addr", {28'd0, wr_addr}, {28'd0, e_wr.a});
            chk("wr_data", {24'd0, wr_data}, {24'd0, e_wr.d});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
      m_ptr = 4'd0;
   endtask

   // ---------------- bit-level master ----------------
   task automatic bit_w(input logic b, input logic coll);
      sda_m = b;
      tick(Q);
      scl_m = 1'b1;
      if (coll) begin
         // Host write lands in the same clock as the I2C register write (3 clocks after the rise)
         tick(2);
         hst_addr  = 4'd5;
         hst_wdata = 8'hFF;
         hst_we    = 1'b1;
         tick(1);
         hst_we    = 1'b0;
         tick(1);
         chk("coll_rdata", {24'd0, hst_rdata}, 32'h33);
         tick(2*Q-4);
      end else begin
         tick(2*Q);
      end
      scl_m = 1'b0;
      tick(Q);
   endtask

   task automatic bit_r(output logic b);
      sda_m = 1'b1;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      b = sda_line;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   // ---------------- byte-level with scoreboard ----------------
   task automatic send(input string tag, input logic [7:0] v, input logic exp_ack, input logic coll);
      logic a;
      exp_bus_q.push_back({7'd0, exp_ack});
      for (int i = 7; i >= 0; i--) bit_w(v[i], coll && (i == 0));
      bit_r(a);
      chk(tag, {31'd0, a}, {24'd0, exp_bus_q.pop_front()});
   endtask

   task automatic wdata(input string tag, input logic [7:0] v, input logic coll);
      wr_t e;
      e.a = m_ptr;
      e.d = v;
      exp_wr_q.push_back(e);
      m_regs[m_ptr] = v;
      m_ptr = m_ptr + 4'd1;
      send(tag, v, 1'b0, coll);
   endtask

   task automatic setptr(input string tag, input logic [7:0] p);
      send(tag, p, 1'b0, 1'b0);
      m_ptr = p[3:0];
   endtask

   task automatic rdata(input string tag, input logic mack);
      logic [7:0] v;
      logic       b;
      exp_bus_q.push_back(m_regs[m_ptr]);
      if (mack == 1'b0) m_ptr = m_ptr + 4'd1;
      for (int i = 7; i >= 0; i--) begin
         bit_r(b);
         v[i] = b;
      end
      bit_w(mack, 1'b0);
      chk(tag, {24'd0, v}, {24'd0, exp_bus_q.pop_front()});
   endtask

   task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
      hst_addr  = a;
      hst_wdata = d;
      hst_we    = 1'b1;
      tick(1);
      hst_we    = 1'b0;
      m_regs[a] = d;
   endtask

   task automatic host_chk(input string tag, input logic [3:0] a);
      hst_addr = a;
      tick(1);
      chk(tag, {24'd0, hst_rdata}, {24'd0, m_regs[a]});
   endtask

   // Watchdog: the stimulus is bounded, this only catches a stuck simulation
   initial begin
      #5_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   int         wr_base;
   int         oen_base;
   logic       b_tmp;

   initial begin
      model_reset();
      tick(5);
      rst = 1'b0;
      tick(2);

      // Reset state
      chk("rst_oen",   {31'd0, sda_oen_o}, 32'd0);
      chk("rst_sda_o", {31'd0, sda_o},     32'd0);
      chk("rst_busy",  {31'd0, busy},      32'd0);
      chk("rst_wrv",   {31'd0, wr_valid},  32'd0);
      chk("rst_wra",   {28'd0, wr_addr},   32'd0);
      chk("rst_wrd",   {24'd0, wr_data},   32'd0);
      chk("rst_hrd",   {24'd0, hst_rdata}, 32'd0);

      // Write: START A0 03 5A STOP
      wr_base = wr_cnt;
      i2c_start();
      send("w_addr", 8'hA0, 1'b0, 1'b0);
      setptr("w_ptr", 8'h03);
      chk("w_busy", {31'd0, busy}, 32'd1);
      wdata("w_data", 8'h5A, 1'b0);
      i2c_stop();
      tick(5);
      chk("w_busy_end", {31'd0, busy}, 32'd0);
      chk("w_pulses", wr_cnt - wr_base, 32'd1);
      host_chk("w_reg3", 4'd3);

      // Combined read with repeated START
      host_wr(4'd4, 8'hC3);
      i2c_start();
      send("r_addr_w", 8'hA0, 1'b0, 1'b0);
      setptr("r_ptr", 8'h03);
      i2c_start();
      send("r_addr_r", 8'hA1, 1'b0, 1'b0);
      rdata("r_byte0", 1'b0);
      rdata("r_byte1", 1'b1);
      tick(2);
      chk("r_nack_rel", {31'd0, sda_oen_o}, 32'd0);
      i2c_stop();
      tick(5);

      // Wrong address
      wr_base  = wr_cnt;
      oen_base = oen_cnt;
      i2c_start();
      send("x_addr", 8'hA2, 1'b1, 1'b0);
      send("x_data", 8'h99, 1'b1, 1'b0);
      i2c_stop();
      tick(5);
      chk("x_oen_cnt", oen_cnt - oen_base, 32'd0);
      chk("x_pulses",  wr_cnt - wr_base,   32'd0);
      host_chk("x_reg3", 4'd3);

      // Pointer wrap
      i2c_start();
      send("p_addr", 8'hA0, 1'b0, 1'b0);
      setptr("p_ptr", 8'h0F);
      wdata("p_d0", 8'h11, 1'b0);
      wdata("p_d1", 8'h22, 1'b0);
      i2c_stop();
      tick(5);
      host_chk("p_reg15", 4'd15);
      host_chk("p_reg0",  4'd0);

      // Host/I2C collision on reg[5]
      i2c_start();
      send("c_addr", 8'hA0, 1'b0, 1'b0);
      setptr("c_ptr", 8'h05);
      wdata("c_data", 8'h33, 1'b1);
      i2c_stop();
      tick(5);
      host_chk("c_reg5", 4'd5);

      // STOP in the middle of a data byte
      wr_base = wr_cnt;
      i2c_start();
      send("s_addr", 8'hA0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) bit_w(1'b1, 1'b0);
      i2c_stop();
      tick(5);
      chk("s_busy",    {31'd0, busy},      32'd0);
      chk("s_oen",     {31'd0, sda_oen_o}, 32'd0);
      chk("s_pulses",  wr_cnt - wr_base,   32'd0);

      // Reset while the address ACK is being driven
      i2c_start();
      for (int i = 7; i >= 0; i--) bit_w(((8'hA0 >> i) & 8'h01) != 8'h00, 1'b0);
      sda_m = 1'b1;
      chk("m_ack_drive", {31'd0, sda_oen_o}, 32'd1);
      rst = 1'b1;
      tick(1);
      chk("m_rst_rel", {31'd0, sda_oen_o}, 32'd0);
      tick(1);
      rst = 1'b0;
      model_reset();
      bit_r(b_tmp);
      chk("m_ack_gone", {31'd0, b_tmp}, 32'd1);
      send("m_ignored", 8'h12, 1'b1, 1'b0);
      i2c_stop();
      tick(5);
      chk("m_busy", {31'd0, busy}, 32'd0);

      // Pointer restarted at 0, next transaction acknowledged
      host_wr(4'd0, 8'hA5);
      host_wr(4'd1, 8'h5C);
      i2c_start();
      send("n_addr", 8'hA1, 1'b0, 1'b0);
      rdata("n_byte0", 1'b0);
      rdata("n_byte1", 1'b1);
      i2c_stop();
      tick(5);

      // Whole register file against the model
      for (int i = 0; i < 16; i++) host_chk("scan_reg", 4'(i));
      chk("wr_pending", exp_wr_q.size(), 32'd0);
      chk("wr_extra",   wr_extra,        32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_i2c_target_regs
`default_nettype wire
